pixel_word_packer: RTL and testbench



---
 rtl/pixel_word_packer.sv | 138 +++++++++++++
 tb/tb_pixel_word_packer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/pixel_word_packer.sv
// pixel_word_packer: packs up to three pixel bytes into a 26-bit tagged word
// {tag[1:0], byte2, byte1, byte0} and buffers words in a first-word
// fall-through FIFO toward the DSP write-data path.
// Optional feature macro: PIXEL_WORD_PACKER_PARITY_EN adds word_par, the XOR
// of all 26 word bits, stored per FIFO entry at push time.
//
// Handshake: a word transfers on a rising edge where word_valid && word_ready.
// word_valid never depends on word_ready; word_data is held stable while
// word_valid=1 and the word is not taken. The pixel input has no backpressure;
// pix_req is only an advisory hint that keeps one word of slack.
module pixel_word_packer #(
  parameter int DEPTH = 4,
  parameter int LW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    pix_data,
  input  logic          pix_valid,
  input  logic          pix_last,
  output logic          pix_req,
  output logic [25:0]   word_data,
  output logic          word_valid,
  input  logic          word_ready,
  output logic [LW-1:0] fifo_level,
  output logic          ovf,
  input  logic          ovf_clr
`ifdef PIXEL_WORD_PACKER_PARITY_EN
  ,
  output logic          word_par
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef PIXEL_WORD_PACKER_PARITY_EN
  localparam int EW = 27;
`else
  localparam int EW = 26;
`endif

  // Packer state: number of bytes held and the partially built word
  logic [1:0]  cnt;
  logic [23:0] acc;

  // FIFO storage and pointers
  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [EW-1:0] head;

  logic [23:0]   merged;
  logic [1:0]    tag;
  logic [25:0]   new_word;
  logic [EW-1:0] new_entry;
  logic          form;
  logic          full;
  logic          pop;
  logic          accept;
  logic          drop;

  // Merge the incoming byte into the accumulator at lane cnt
  always_comb begin
    merged = acc;
    case (cnt)
      2'd0:    merged[7:0]   = pix_data;
      2'd1:    merged[15:8]  = pix_data;
      default: merged[23:16] = pix_data;
    endcase
  end

  assign form     = pix_valid && ((cnt == 2'd2) || pix_last);
  assign tag      = cnt + 2'd1;
  assign new_word = {tag, merged};
`ifdef PIXEL_WORD_PACKER_PARITY_EN
  assign new_entry = {^new_word, new_word};
`else
  assign new_entry = new_word;
`endif

  assign full   = (fifo_level == LW'(DEPTH));
  assign pop    = word_valid && word_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts
  assign accept = form && (!full || pop);
  assign drop   = form && full && !pop;

  // Packer: accumulate bytes, clear after each formed word
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 2'd0;
      acc <= 24'd0;
    end else if (pix_valid) begin
      if (form) begin
        cnt <= 2'd0;
        acc <= 24'd0;
      end else begin
        cnt <= cnt + 2'd1;
        acc <= merged;
      end
    end
  end

  // FIFO storage write; contents past fifo_level are never observed
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= new_entry;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PW'(1);
      if (pop)    rd_ptr <= rd_ptr + PW'(1);
      case ({accept, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Sticky overflow; a new drop wins over a simultaneous clear
  always_ff @(posedge clk) begin
    if (rst)          ovf <= 1'b0;
    else if (drop)    ovf <= 1'b1;
    else if (ovf_clr) ovf <= 1'b0;
  end

  assign head       = mem[rd_ptr];
  assign word_valid = (fifo_level != '0);
  assign word_data  = word_valid ? head[25:0] : 26'd0;
  assign pix_req    = (fifo_level < LW'(DEPTH - 1));
`ifdef PIXEL_WORD_PACKER_PARITY_EN
  assign word_par   = word_valid ? head[26] : 1'b0;
`endif

endmodule

// File: tb/tb_pixel_word_packer.sv
// Bench for pixel_word_packer: directed scenarios plus random traffic, all
// outputs compared every cycle against a queue-based reference model.
module tb_pixel_word_packer;

  localparam int DEPTH = 4;
  localparam int LW    = 3;

  // Clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic [7:0]    pix_data = 8'd0;
  logic          pix_valid = 1'b0;
  logic          pix_last = 1'b0;
  logic          pix_req;
  logic [25:0]   word_data;
  logic          word_valid;
  logic          word_ready = 1'b0;
  logic [LW-1:0] fifo_level;
  logic          ovf;
  logic          ovf_clr = 1'b0;
`ifdef PIXEL_WORD_PACKER_PARITY_EN
  logic          word_par;
`endif

  pixel_word_packer #(.DEPTH(DEPTH), .LW(LW)) dut (
    .clk(clk),
    .rst(rst),
    .pix_data(pix_data),
    .pix_valid(pix_valid),
    .pix_last(pix_last),
    .pix_req(pix_req),
    .word_data(word_data),
    .word_valid(word_valid),
    .word_ready(word_ready),
    .fifo_level(fifo_level),
    .ovf(ovf),
    .ovf_clr(ovf_clr)
`ifdef PIXEL_WORD_PACKER_PARITY_EN
    ,
    .word_par(word_par)
`endif
  );

  // Scoreboard state
  int total = 0;
  int bad   = 0;
  logic [25:0] exp_q[$];
  logic [7:0]  pend_q[$];
  logic        m_ovf = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one clock edge with the inputs currently driven
  task automatic model_edge();
    logic [25:0] w;
    logic        formed;
    logic        popped;
    logic        dropped;
    if (rst) begin
      exp_q.delete();
      pend_q.delete();
      m_ovf = 1'b0;
      return;
    end
    formed  = 1'b0;
    dropped = 1'b0;
    w       = 26'd0;
    popped  = (exp_q.size() != 0) && word_ready;
    if (pix_valid) begin
      pend_q.push_back(pix_data);
      if (pend_q.size() == 3 || pix_last) begin
        for (int i = 0; i < pend_q.size(); i++) w[8*i +: 8] = pend_q[i];
        w[25:24] = 2'(pend_q.size());
        pend_q.delete();
        formed = 1'b1;
      end
    end
    if (formed && exp_q.size() == DEPTH && !popped) dropped = 1'b1;
    if (popped) void'(exp_q.pop_front());
    if (formed && !dropped) exp_q.push_back(w);
    if (dropped) m_ovf = 1'b1;
    else if (ovf_clr) m_ovf = 1'b0;
  endtask

  // Compare every output against the model
  task automatic check_outputs();
    logic [25:0] ew;
    ew = (exp_q.size() != 0) ? exp_q[0] : 26'd0;
    check("word_valid", 32'(word_valid), 32'(exp_q.size() != 0));
    check("word_data", 32'(word_data), 32'(ew));
    check("fifo_level", 32'(fifo_level), 32'(exp_q.size()));
    check("pix_req", 32'(pix_req), 32'(exp_q.size() < DEPTH - 1));
    check("ovf", 32'(ovf), 32'(m_ovf));
`ifdef PIXEL_WORD_PACKER_PARITY_EN
    check("word_par", 32'(word_par), 32'(^ew));
`endif
  endtask

  // Driver tasks: inputs change at the negedge, outputs checked at the negedge
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic last,
                       input logic rdy, input logic clr);
    pix_valid  = v;
    pix_data   = d;
    pix_last   = last;
    word_ready = rdy;
    ovf_clr    = clr;
    tick();
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0, rdy, 1'b0);
  endtask

  initial begin
    // Reset, then ten idle cycles
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    idle(10, 1'b0);
    check("rst_level", 32'(fifo_level), 32'd0);

    // Three full beats
    drive(1'b1, 8'h11, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 8'h22, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 8'h33, 1'b0, 1'b1, 1'b0);
    check("word3_data", 32'(word_data), 32'h3332211);
    check("word3_valid", 32'(word_valid), 32'd1);
    idle(1, 1'b1);
    check("word3_gone", 32'(word_valid), 32'd0);

    // Short words ended by pix_last
    drive(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'hBB, 1'b1, 1'b0, 1'b0);
    check("word2_data", 32'(word_data), 32'h200BBAA);
    drive(1'b0, 8'hFF, 1'b1, 1'b1, 1'b0);   // pix_last without valid is ignored
    drive(1'b1, 8'hCC, 1'b1, 1'b0, 1'b0);
    check("word1_data", 32'(word_data), 32'h10000CC);
    idle(2, 1'b1);

    // Overflow: 15 beats, no readiness
    for (int i = 0; i < 15; i++) drive(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
    check("ovf_level", 32'(fifo_level), 32'd4);
    check("ovf_set", 32'(ovf), 32'd1);
    check("ovf_req", 32'(pix_req), 32'd0);
    idle(4, 1'b1);
    check("ovf_sticky", 32'(ovf), 32'd1);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("ovf_cleared", 32'(ovf), 32'd0);

    // Full FIFO with a pop in the completing cycle
    for (int i = 0; i < 14; i++) drive(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h8E, 1'b0, 1'b1, 1'b0);
    check("full_pop_level", 32'(fifo_level), 32'd4);
    check("full_pop_ovf", 32'(ovf), 32'd0);
    idle(6, 1'b1);

    // Reset mid-line discards partial bytes
    drive(1'b1, 8'hE1, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 8'hE2, 1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    rst = 1'b0;
    drive(1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h02, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h03, 1'b0, 1'b0, 1'b0);
    check("post_rst_word", 32'(word_data), 32'h3030201);
`ifdef PIXEL_WORD_PACKER_PARITY_EN
    check("post_rst_par", 32'(word_par), 32'd0);
`endif
    idle(2, 1'b1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      drive(1'($urandom_range(0, 3) != 0), 8'($urandom),
            1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 15) == 0));
    end
    rst = 1'b0;
    idle(8, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
